// File: rtl/vga_timing_controller.sv
// vga_timing_controller
// Pixel/line/frame counters that drive frame-buffer read strobes. A short
// pipeline carries sync and blanking information alongside each read, so the
// returning pixel data and the sync pulses leave the block on the same edge.

module vga_timing_controller #(
    parameter int H_VIS    = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_VIS    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 2,
    parameter int COLOR_W  = 1,
    parameter int SYNC_POL = 0,
    localparam int AW      = $clog2(H_VIS * V_VIS)
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   Enable,
    input  logic [3*COLOR_W-1:0]   iPixel,
    output logic                   oReadEnable,
    output logic [AW-1:0]          oReadAddress,
    output logic                   oHorizontalSync,
    output logic                   oVerticalSync,
    output logic [COLOR_W-1:0]     oRed,
    output logic [COLOR_W-1:0]     oGreen,
    output logic [COLOR_W-1:0]     oBlue,
    output logic                   oFrameStart
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HW    = (H_TOT > 1) ? $clog2(H_TOT) : 1;
    localparam int VW    = (V_TOT > 1) ? $clog2(V_TOT) : 1;
    localparam int PW    = 3 * COLOR_W;

    localparam logic [DW-1:0] D_LAST   = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_VIS_L  = HW'(H_VIS);
    localparam logic [HW-1:0] HS_FIRST = HW'(H_VIS + H_FP);
    localparam logic [HW-1:0] HS_LAST  = HW'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_VIS_L  = VW'(V_VIS);
    localparam logic [VW-1:0] VS_FIRST = VW'(V_VIS + V_FP);
    localparam logic [VW-1:0] VS_LAST  = VW'(V_VIS + V_FP + V_SYNC - 1);
    localparam logic          SYNC_ON  = (SYNC_POL != 0);

    logic [DW-1:0] divCount;
    logic [HW-1:0] hCount;
    logic [VW-1:0] vCount;
    logic [AW-1:0] addrCount;

    logic pixelTick;
    logic lineEnd;
    logic frameEnd;
    logic visibleNow;
    logic strobeNow;
    logic firstPixelNow;
    logic hsNow;
    logic vsNow;

    // Stage 1 and 2 carry per-cycle timing info while the frame buffer answers.
    logic rd1, vis1, hs1, vs1, fs1;
    logic rd2, vis2, hs2, vs2, fs2;

    // Small return buffer: pixel data keeps arriving while the timing is frozen.
    logic [PW-1:0] pixBuf [2];
    logic          wrPtr;
    logic          rdPtr;
    logic [1:0]    pixCount;
    logic          rdPend;
    logic          pixPush;
    logic          pixPop;
    logic [PW-1:0] pixelNext;

    // Decode the current counter position into strobe, blanking and sync flags.
    always_comb begin
        pixelTick     = (divCount == D_LAST);
        lineEnd       = pixelTick && (hCount == H_LAST);
        frameEnd      = lineEnd && (vCount == V_LAST);
        visibleNow    = (hCount < H_VIS_L) && (vCount < V_VIS_L);
        strobeNow     = (divCount == '0) && visibleNow;
        firstPixelNow = (divCount == '0) && (hCount == '0) && (vCount == '0);
        hsNow         = (hCount >= HS_FIRST) && (hCount <= HS_LAST);
        vsNow         = (vCount >= VS_FIRST) && (vCount <= VS_LAST);
        pixPush       = rdPend;
        pixPop        = Enable && rd2;
        pixelNext     = (pixCount == 2'd0) ? iPixel : pixBuf[rdPtr];
    end

    // Divider, column and row counters advance only while enabled.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            divCount <= '0;
            hCount   <= '0;
            vCount   <= '0;
        end else if (Enable) begin
            divCount <= pixelTick ? '0 : divCount + DW'(1);
            if (pixelTick) begin
                hCount <= lineEnd ? '0 : hCount + HW'(1);
            end
            if (lineEnd) begin
                vCount <= frameEnd ? '0 : vCount + VW'(1);
            end
        end
    end

    // Linear read address counts visible pixels and clears at the frame wrap.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            addrCount <= '0;
        end else if (Enable) begin
            if (frameEnd) begin
                addrCount <= '0;
            end else if (strobeNow) begin
                addrCount <= addrCount + AW'(1);
            end
        end
    end

    // Registered read strobe and address; the strobe is forced low while frozen.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            oReadEnable  <= 1'b0;
            oReadAddress <= '0;
        end else if (Enable) begin
            oReadEnable <= strobeNow;
            if (strobeNow) begin
                oReadAddress <= addrCount;
            end
        end else begin
            oReadEnable <= 1'b0;
        end
    end

    // Two pipeline stages that match the frame-buffer read latency.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            {rd1, vis1, hs1, vs1, fs1} <= '0;
            {rd2, vis2, hs2, vs2, fs2} <= '0;
        end else if (Enable) begin
            rd1  <= strobeNow;
            vis1 <= visibleNow;
            hs1  <= hsNow;
            vs1  <= vsNow;
            fs1  <= firstPixelNow;
            rd2  <= rd1;
            vis2 <= vis1;
            hs2  <= hs1;
            vs2  <= vs1;
            fs2  <= fs1;
        end
    end

    // Return-buffer bookkeeping: data is valid the cycle after the memory saw a strobe.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            rdPend   <= 1'b0;
            wrPtr    <= 1'b0;
            rdPtr    <= 1'b0;
            pixCount <= 2'd0;
        end else begin
            rdPend <= oReadEnable;
            if (pixPush) begin
                wrPtr <= ~wrPtr;
            end
            if (pixPop) begin
                rdPtr <= ~rdPtr;
            end
            case ({pixPush, pixPop})
                2'b10:   pixCount <= pixCount + 2'd1;
                2'b01:   pixCount <= pixCount - 2'd1;
                default: pixCount <= pixCount;
            endcase
        end
    end

    // Return-buffer storage needs no reset; occupancy tracking guards it.
    always_ff @(posedge Clock) begin
        if (pixPush) begin
            pixBuf[wrPtr] <= iPixel;
        end
    end

    // Output stage: colours, syncs and frame marker all change on the same edge.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            oRed            <= '0;
            oGreen          <= '0;
            oBlue           <= '0;
            oHorizontalSync <= ~SYNC_ON;
            oVerticalSync   <= ~SYNC_ON;
            oFrameStart     <= 1'b0;
        end else if (Enable) begin
            oHorizontalSync <= hs2 ? SYNC_ON : ~SYNC_ON;
            oVerticalSync   <= vs2 ? SYNC_ON : ~SYNC_ON;
            oFrameStart     <= fs2;
            if (!vis2) begin
                {oRed, oGreen, oBlue} <= '0;
            end else if (rd2) begin
                {oRed, oGreen, oBlue} <= pixelNext;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_controller.sv
// tb_vga_timing_controller
// Two controllers (divide-by-2 and divide-by-1) share clock and controls.
// A reference model derived from the frame geometry predicts every output
// cycle into queues; a monitor pops and compares on the opposite clock edge.

module tb_vga_timing_controller;

    localparam int HV = 4;
    localparam int HF = 1;
    localparam int HSY = 2;
    localparam int HB = 1;
    localparam int VV = 3;
    localparam int VF = 1;
    localparam int VSY = 1;
    localparam int VB = 1;
    localparam int HT = HV + HF + HSY + HB;
    localparam int VT = VV + VF + VSY + VB;
    localparam int AW = $clog2(HV * VV);

    typedef struct packed {
        logic          re;
        logic [AW-1:0] addr;
        logic          hs;
        logic          vs;
        logic [2:0]    rgb;
        logic          fs;
    } outs_t;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    logic Enable = 1'b1;

    logic          re0, hs0, vs0, fs0, r0, g0, b0;
    logic [AW-1:0] addr0;
    logic [2:0]    pix0 = 3'b000;
    logic          re1, hs1, vs1, fs1, r1, g1, b1;
    logic [AW-1:0] addr1;
    logic [2:0]    pix1 = 3'b000;

    outs_t act0, act1;
    assign act0 = {re0, addr0, hs0, vs0, r0, g0, b0, fs0};
    assign act1 = {re1, addr1, hs1, vs1, r1, g1, b1, fs1};

    int compared = 0;
    int mismatched = 0;

    outs_t         expQ0[$];
    outs_t         expQ1[$];
    logic [AW-1:0] addrQ0[$];
    logic [AW-1:0] addrQ1[$];
    outs_t         expCur [2];
    int            kk [2];
    bit            modelOn = 1'b0;

    always #5 Clock = ~Clock;

    vga_timing_controller #(
        .H_VIS(HV), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
        .CLK_DIV(2), .COLOR_W(1), .SYNC_POL(0)
    ) dut0 (
        .Clock(Clock), .Reset(Reset), .Enable(Enable), .iPixel(pix0),
        .oReadEnable(re0), .oReadAddress(addr0),
        .oHorizontalSync(hs0), .oVerticalSync(vs0),
        .oRed(r0), .oGreen(g0), .oBlue(b0), .oFrameStart(fs0)
    );

    vga_timing_controller #(
        .H_VIS(HV), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
        .CLK_DIV(1), .COLOR_W(1), .SYNC_POL(0)
    ) dut1 (
        .Clock(Clock), .Reset(Reset), .Enable(Enable), .iPixel(pix1),
        .oReadEnable(re1), .oReadAddress(addr1),
        .oHorizontalSync(hs1), .oVerticalSync(vs1),
        .oRed(r1), .oGreen(g1), .oBlue(b1), .oFrameStart(fs1)
    );

    // Frame-buffer models: synchronous read returning the low address bits.
    always @(posedge Clock) begin
        if (re0) pix0 <= addr0[2:0];
        if (re1) pix1 <= addr1[2:0];
    end

    function automatic outs_t resetOut();
        outs_t o;
        o.re = 1'b0; o.addr = '0; o.hs = 1'b1; o.vs = 1'b1; o.rgb = 3'b000; o.fs = 1'b0;
        return o;
    endfunction

    // Screen position of enabled-cycle index p since reset.
    function automatic void posOf(input int cd, input int p, output int d, output int h, output int v);
        d = p % cd;
        h = (p / cd) % HT;
        v = (p / (cd * HT)) % VT;
    endfunction

    function automatic bit isStrobe(input int cd, input int p);
        int d, h, v;
        posOf(cd, p, d, h, v);
        return (d == 0) && (h < HV) && (v < VV);
    endfunction

    function automatic logic [AW-1:0] addrOf(input int cd, input int p);
        int d, h, v;
        posOf(cd, p, d, h, v);
        return AW'(v * HV + h);
    endfunction

    // What the screen shows for position p: colour, syncs, frame marker.
    function automatic outs_t screenOf(input int cd, input int p);
        outs_t o;
        int d, h, v, a;
        posOf(cd, p, d, h, v);
        a = v * HV + h;
        o = resetOut();
        o.rgb = ((h < HV) && (v < VV)) ? a[2:0] : 3'b000;
        o.hs = (h >= HV + HF && h < HV + HF + HSY) ? 1'b0 : 1'b1;
        o.vs = (v >= VV + VF && v < VV + VF + VSY) ? 1'b0 : 1'b1;
        o.fs = ((p % (cd * HT * VT)) == 0);
        return o;
    endfunction

    task automatic modelEdge(input int i);
        int    cd;
        outs_t e;
        outs_t s;
        cd = (i == 0) ? 2 : 1;
        e = expCur[i];
        if (Reset) begin
            kk[i] = 0;
            e = resetOut();
            if (i == 0) addrQ0.delete(); else addrQ1.delete();
        end else if (Enable) begin
            kk[i]++;
            e.re = isStrobe(cd, kk[i] - 1);
            if (e.re) begin
                e.addr = addrOf(cd, kk[i] - 1);
                if (i == 0) addrQ0.push_back(e.addr); else addrQ1.push_back(e.addr);
            end
            s = (kk[i] >= 3) ? screenOf(cd, kk[i] - 3) : resetOut();
            e.hs = s.hs; e.vs = s.vs; e.rgb = s.rgb; e.fs = s.fs;
        end else begin
            e.re = 1'b0;
        end
        expCur[i] = e;
        if (i == 0) expQ0.push_back(e); else expQ1.push_back(e);
    endtask

    // Reference model: predicts the outputs that follow each clock edge.
    always @(posedge Clock) begin
        if (Reset) modelOn = 1'b1;
        if (modelOn) begin
            for (int i = 0; i < 2; i++) modelEdge(i);
        end
    end

    task automatic checkOutput(input string name, input outs_t got, input outs_t want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL %s t=%0t got re=%b addr=%0d hs=%b vs=%b rgb=%b fs=%b want re=%b addr=%0d hs=%b vs=%b rgb=%b fs=%b",
                     name, $time, got.re, got.addr, got.hs, got.vs, got.rgb, got.fs,
                     want.re, want.addr, want.hs, want.vs, want.rgb, want.fs);
        end
    endtask

    task automatic checkCount(input string name, input int got, input int want);
        compared++;
        if (got != want) begin
            mismatched++;
            $display("[TB] FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic checkStrobe(input string name, input logic [AW-1:0] got, inout logic [AW-1:0] q[$]);
        compared++;
        if (q.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL %s unexpected strobe addr=%0d", name, got);
        end else if (got !== q[0]) begin
            mismatched++;
            $display("[TB] FAIL %s got addr %0d want %0d", name, got, q[0]);
            void'(q.pop_front());
        end else begin
            void'(q.pop_front());
        end
    endtask

    // Monitor: compares every predicted cycle and every read strobe.
    always @(negedge Clock) begin
        if (expQ0.size() > 0) checkOutput("cycle_div2", act0, expQ0.pop_front());
        if (expQ1.size() > 0) checkOutput("cycle_div1", act1, expQ1.pop_front());
        if (re0 === 1'b1) checkStrobe("strobe_div2", addr0, addrQ0);
        if (re1 === 1'b1) checkStrobe("strobe_div1", addr1, addrQ1);
    end

    task automatic applyStimulus(input bit rst, input bit en, input int cycles);
        Reset = rst;
        Enable = en;
        repeat (cycles) @(negedge Clock);
    endtask

    task automatic countFrame();
        int n0 = 0, f0 = 0, n1 = 0, f1 = 0;
        for (int c = 0; c < 96; c++) begin
            @(posedge Clock);
            #1;
            if (re0) n0++;
            if (fs0) f0++;
            if (c < 48) begin
                if (re1) n1++;
                if (fs1) f1++;
            end
        end
        @(negedge Clock);
        checkCount("frame_strobes_div2", n0, 12);
        checkCount("frame_starts_div2", f0, 1);
        checkCount("frame_strobes_div1", n1, 12);
        checkCount("frame_starts_div1", f1, 1);
    endtask

    task automatic waitAddr(input int target);
        bit found = 1'b0;
        for (int c = 0; c < 300 && !found; c++) begin
            @(posedge Clock);
            #1;
            if (re0 && addr0 == AW'(target)) found = 1'b1;
        end
        @(negedge Clock);
        compared++;
        if (!found) begin
            mismatched++;
            $display("[TB] FAIL wait_addr_%0d got timeout want strobe", target);
        end
    endtask

    initial begin
        applyStimulus(1'b1, 1'b1, 3);
        checkOutput("reset_state_div2", act0, resetOut());
        checkOutput("reset_state_div1", act1, resetOut());

        Reset = 1'b0;
        countFrame();

        waitAddr(5);
        applyStimulus(1'b0, 1'b0, 7);
        applyStimulus(1'b0, 1'b1, 0);
        waitAddr(6);

        waitAddr(7);
        applyStimulus(1'b1, 1'b1, 1);
        checkOutput("midframe_reset_div2", act0, resetOut());
        applyStimulus(1'b0, 1'b1, 0);
        countFrame();

        for (int c = 0; c < 400; c++) begin
            applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, 1);
        end
        applyStimulus(1'b0, 1'b1, 120);
        applyStimulus(1'b0, 1'b0, 4);

        checkCount("leftover_strobes_div2", addrQ0.size(), 0);
        checkCount("leftover_strobes_div1", addrQ1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/vga_timing_controller.md
VGA_TIMING_CONTROLLER -- requirements
Module: vga_timing_controller

Interface
REQ-001 SHALL have parameter H_VIS, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48, horizontal front porch / sync / back porch in pixels.
REQ-003 SHALL have parameter V_VIS, default 480, visible lines per frame.
REQ-004 SHALL have parameters V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33, vertical front porch / sync / back porch in lines.
REQ-005 SHALL have parameter CLK_DIV, default 2, Clock cycles per pixel (>=1).
REQ-006 SHALL have parameter COLOR_W, default 1, bits per colour channel.
REQ-007 SHALL have parameter SYNC_POL, default 0, sync active level (0 = active-low).
REQ-008 SHALL have port Clock  input  1  the single clock; all logic on its rising edge.
REQ-009 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-010 SHALL have port Enable  input  1  advance timing when high; freeze when low.
REQ-011 SHALL have port iPixel  input  3*COLOR_W  {R,G,B} read data, valid one Clock after oReadEnable.
REQ-012 SHALL have port oReadEnable  output  1  frame-buffer read strobe.
REQ-013 SHALL have port oReadAddress  output  AW  linear pixel address, AW = clog2(H_VIS*V_VIS).
REQ-014 SHALL have ports oHorizontalSync / oVerticalSync  output  1 each  sync pulses.
REQ-015 SHALL have ports oRed / oGreen / oBlue  output  COLOR_W each  colour outputs.
REQ-016 SHALL have port oFrameStart  output  1  one-cycle pulse with first visible pixel output.

Function
REQ-017 SHALL keep divider d (0..CLK_DIV-1), column h (0..H_TOT-1, H_TOT = H_VIS+H_FP+H_SYNC+H_BP), row v (0..V_TOT-1, V_TOT defined the same way).
REQ-018 SHALL advance d each Clock with Enable=1; at d=CLK_DIV-1, d->0 and h increments; h wraps H_TOT-1->0 and increments v; v wraps V_TOT-1->0.
REQ-019 SHALL treat (h,v) as visible iff h<H_VIS and v<V_VIS.
REQ-020 SHALL, in the cycle with d=0 and (h,v) visible, register oReadEnable=1 and oReadAddress=current linear address; oReadEnable SHALL be 0 otherwise.
REQ-021 SHALL generate the address with an incrementing counter, no multiplier: +1 per visible pixel, 0 at frame wrap; sequence 0..H_VIS*V_VIS-1.
REQ-022 SHALL register iPixel onto oRed/oGreen/oBlue one Clock after oReadEnable and hold it for CLK_DIV cycles.
REQ-023 SHALL drive colours 0 for non-visible pixel periods.
REQ-024 SHALL assert HS for h in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1] and VS for v in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC-1].
REQ-025 SHALL delay both syncs through the same 2-stage pipeline as the colours, so sync and colour edges stay aligned.
REQ-026 SHALL drive sync outputs at SYNC_POL when asserted and !SYNC_POL otherwise.
REQ-027 SHALL pulse oFrameStart for one Clock, coincident with the first colour cycle of pixel (0,0).
REQ-028 SHALL, while Enable=0, hold all counters and pipeline registers and all outputs; oReadEnable SHALL be 0.
REQ-029 SHALL, on resume, continue with no skipped or duplicated address.
REQ-030 SHALL, with CLK_DIV=1, issue oReadEnable every visible cycle and keep the same 2-cycle latency.

Reset
REQ-031 SHALL, when Reset=1 on a Clock edge, set d=h=v=0, address 0, oReadEnable=0, colours 0, oFrameStart=0, syncs inactive (!SYNC_POL).
REQ-032 SHALL let Reset override Enable.
REQ-033 SHALL, after Reset mid-frame, restart at pixel (0,0), address 0.

Verification (bench params unless stated: H 4/1/2/1, H_TOT=8; V 3/1/1/1, V_TOT=6; CLK_DIV=2, COLOR_W=1, SYNC_POL=0)
REQ-034 SHALL cover reset: Reset held 3 cycles -> HS=VS=1, colours 000, oReadEnable=0, oReadAddress=0.
REQ-035 SHALL cover a full frame: 96 Clocks/frame; exactly 12 oReadEnable pulses, addresses 0..11 in order, then 0; oFrameStart once.
REQ-036 SHALL cover sync timing: HS low 4 Clocks per line starting 10 Clocks after the pixel h=0 slot plus 2-cycle pipeline; VS low 16 Clocks per frame.
REQ-037 SHALL cover pixel data: model RAM returns iPixel=address[2:0] one cycle after the strobe -> colours equal address[2:0] for each visible pixel, 000 in blanking, aligned to sync edges.
REQ-038 SHALL cover Enable gating: Enable=0 for 7 Clocks at address 5 -> outputs frozen, oReadEnable=0; after resume next address is 6.
REQ-039 SHALL cover mid-frame reset: Reset pulse at address 7 -> reset values next cycle; next strobes start at 0; oFrameStart follows. Repeat REQ-035 with CLK_DIV=1 -> 48 Clocks/frame.
